if_id_queue: RTL and testbench

Decoupling buffer between the instruction-fetch stage and the decode stage of the five-stage MIPS pipeline. It accepts fetched {pc, instr} pairs from IF under a valid/ready handshake, holds up to DEPTH of them in order, and presents the oldest to ID. When the queue is empty it presents a NOP. A branch/exception flush empties it in one cycle. A saturating counter records decode-starved cycles for performance analysis.

---
 rtl/if_id_queue.sv | 75 +++++++
 tb/tb_if_id_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: in-order buffer of {pc, instr} pairs between fetch and decode,
// with single-cycle flush, NOP presentation when empty and a saturating starvation counter.
module if_id_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  // Ready comes from registered count only, so a pop never opens a slot in the same cycle.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally left out of reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_pc, in_instr};
  end

  assign head      = mem[rd_ptr];
  assign out_pc    = out_valid ? head[63:32] : '0;
  assign out_instr = out_valid ? head[31:0]  : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (out_ready && !out_valid && !flush && !(&starve_cnt)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: table-driven cycle vectors with a reference queue
// scoreboard, plus hand sequences for mid-cycle reset and starvation saturation.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready,  in_ready_s;
  logic        out_valid, out_valid_s;
  logic [31:0] out_pc,    out_pc_s;
  logic [31:0] out_instr, out_instr_s;
  logic [15:0] starve_cnt;
  logic [2:0]  starve_cnt_s;

  if_id_queue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .starve_cnt(starve_cnt)
  );

  if_id_queue #(.DEPTH(DEPTH), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_pc(out_pc_s), .out_instr(out_instr_s), .out_ready(out_ready),
    .starve_cnt(starve_cnt_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        flush;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        out_ready;
    logic        exp_ready;
    logic        exp_valid;
  } vec_t;

  vec_t        tv[$];
  logic [63:0] sb[$];
  int          starve_m;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic fl, input logic iv,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic orr, input logic er, input logic ev);
    vec_t v;
    v.name = nm; v.flush = fl; v.in_valid = iv; v.pc = pc; v.instr = ins;
    v.out_ready = orr; v.exp_ready = er; v.exp_valid = ev;
    tv.push_back(v);
  endfunction

  // Called just after a rising edge; drives one cycle and checks the state after the next edge.
  task automatic step(input vec_t v);
    logic push_m, pop_m, starve_inc;
    flush     = v.flush;
    in_valid  = v.in_valid;
    in_pc     = v.pc;
    in_instr  = v.instr;
    out_ready = v.out_ready;
    @(negedge clk);
    push_m     = v.in_valid && (sb.size() != DEPTH) && !v.flush;
    pop_m      = (sb.size() != 0) && v.out_ready && !v.flush;
    starve_inc = v.out_ready && (sb.size() == 0) && !v.flush;
    if (pop_m) begin
      chk({v.name, " pop_pc"},    out_pc,    sb[0][63:32]);
      chk({v.name, " pop_instr"}, out_instr, sb[0][31:0]);
    end
    @(posedge clk);
    #1;
    if (v.flush) sb.delete();
    else begin
      if (pop_m)  void'(sb.pop_front());
      if (push_m) sb.push_back({v.pc, v.instr});
    end
    if (starve_inc) starve_m++;
    chk({v.name, " in_ready"},  {31'd0, in_ready},  {31'd0, v.exp_ready});
    chk({v.name, " out_valid"}, {31'd0, out_valid}, {31'd0, v.exp_valid});
    if (sb.size() == 0) begin
      chk({v.name, " nop_pc"},    out_pc,    32'h0);
      chk({v.name, " nop_instr"}, out_instr, 32'h0);
    end else begin
      chk({v.name, " head_pc"},    out_pc,    sb[0][63:32]);
      chk({v.name, " head_instr"}, out_instr, sb[0][31:0]);
    end
    chk({v.name, " starve"},     {16'd0, starve_cnt},   starve_m);
    chk({v.name, " starve_sat"}, {29'd0, starve_cnt_s}, (starve_m > 7) ? 7 : starve_m);
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    starve_m = 0;

    @(posedge clk);
    #2;
    chk("rst in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_pc",    out_pc,    32'h0);
    chk("rst out_instr", out_instr, 32'h0);
    chk("rst starve",    {16'd0, starve_cnt}, 32'd0);
    rst = 1'b1;

    // fill with out_ready low, reject third, then drain in order
    add("fill0",  0, 1, 32'h0040_0000, 32'h2008_0005, 0, 1, 1);
    add("fill1",  0, 1, 32'h0040_0004, 32'h2009_0003, 0, 0, 1);
    add("full",   0, 1, 32'h0040_0008, 32'hDEAD_BEEF, 0, 0, 1);
    add("drain0", 0, 0, 32'h0,         32'h0,         1, 1, 1);
    add("drain1", 0, 0, 32'h0,         32'h0,         1, 1, 0);
    add("empty",  0, 0, 32'h0,         32'h0,         0, 1, 0);
    // streaming push+pop with pointer wrap
    for (int unsigned n = 0; n < 10; n++)
      add($sformatf("stream%0d", n), 0, 1, 32'h0040_0000 + 4 * n, 32'h1000_0000 + n, 1, 1, 1);
    add("stream_drain", 0, 0, 32'h0, 32'h0, 1, 1, 0);
    // flush with concurrent push and pop
    add("pre_fl0", 0, 1, 32'h0040_0010, 32'h2010_0001, 0, 1, 1);
    add("pre_fl1", 0, 1, 32'h0040_0014, 32'h2010_0002, 0, 0, 1);
    add("flush",   1, 1, 32'h0040_0100, 32'h2010_0100, 1, 1, 0);
    add("post_fl", 0, 1, 32'h0040_0200, 32'h2010_0200, 0, 1, 1);
    add("post_dr", 0, 0, 32'h0,         32'h0,         1, 1, 0);

    #1;
    for (int i = 0; i < tv.size(); i++) step(tv[i]);

    // asynchronous reset mid-cycle with two entries held
    begin
      vec_t v;
      v.name = "hold0"; v.flush = 0; v.in_valid = 1; v.pc = 32'h0040_0300;
      v.instr = 32'h2011_0001; v.out_ready = 0; v.exp_ready = 1; v.exp_valid = 1;
      step(v);
      v.name = "hold1"; v.pc = 32'h0040_0304; v.instr = 32'h2011_0002; v.exp_ready = 0;
      step(v);
    end
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst out_pc",    out_pc,    32'h0);
    chk("mid_rst out_instr", out_instr, 32'h0);
    chk("mid_rst starve",    {16'd0, starve_cnt}, 32'd0);
    sb.delete();
    starve_m = 0;
    rst = 1'b1;

    // starvation: 5 cycles, then 10 to saturate the 3-bit counter
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      v.name = $sformatf("starve%0d", i); v.flush = 0; v.in_valid = 0; v.pc = '0;
      v.instr = '0; v.out_ready = 1; v.exp_ready = 1; v.exp_valid = 0;
      step(v);
      if (i == 4) chk("starve_five", {16'd0, starve_cnt}, 32'd5);
    end
    chk("starve_ten",       {16'd0, starve_cnt},   32'd10);
    chk("starve_saturated", {29'd0, starve_cnt_s}, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
